// File: rtl/updi_double_break_gen.sv
// -----------------------------------------------------------------------------
// updi_double_break_gen
//
// Drives the UPDI double-break sequence that resets the target's UPDI link
// before programming. It waits for the UART TX path to drain, then takes over
// the line: low (BREAK_CYCLES), high (GAP_CYCLES), low (BREAK_CYCLES) and,
// when UPDI_DB_GUARD_EN is defined, a trailing high guard (GUARD_CYCLES).
//
// Build option:
//   UPDI_DB_GUARD_EN  when defined, compiles in the GUARD state after BREAK2.
//                     When undefined, BREAK2 goes straight to DONE and
//                     GUARD_CYCLES only takes part in sizing the counter.
//
// Ports:
//   clk            clock
//   rst            synchronous, active-high reset
//   start          single-cycle request (double_break_start)
//   busy           high while a sequence is in progress
//   done           sticky completion flag, cleared by the next accepted start
//   uart_tx_idle   high when the UART TX FIFO is empty and the shifter is idle
//   line_override  pad drives line_value instead of the UART TX output
//   line_value     level driven on the UPDI line while overridden (1 otherwise)
//   uart_rx_flush  one-cycle pulse on the first DONE cycle
//   state_dbg      registered FSM state, for observation only
//
// Handshake: start is a request pulse with an implicit ready of !busy. It is
// accepted only in IDLE or DONE (busy=0); a start seen while busy=1 is
// dropped, not queued. rst takes priority over start on the same edge.
// -----------------------------------------------------------------------------
module updi_double_break_gen #(
  parameter int BREAK_CYCLES = 1230000,
  parameter int GAP_CYCLES   = 50000,
  parameter int GUARD_CYCLES = 5000,
  parameter int CNT_BITS     = $clog2(
    (((BREAK_CYCLES > GAP_CYCLES) ? BREAK_CYCLES : GAP_CYCLES) > GUARD_CYCLES ?
     ((BREAK_CYCLES > GAP_CYCLES) ? BREAK_CYCLES : GAP_CYCLES) : GUARD_CYCLES) + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  input  logic       uart_tx_idle,
  output logic       line_override,
  output logic       line_value,
  output logic       uart_rx_flush,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_TX = 3'd1,
    S_BREAK1  = 3'd2,
    S_GAP     = 3'd3,
    S_BREAK2  = 3'd4,
`ifdef UPDI_DB_GUARD_EN
    S_GUARD   = 3'd5,
`endif
    S_DONE    = 3'd6
  } state_t;

  // Each phase loads N-1 and leaves when the counter reads 0, so it lasts
  // exactly N cycles.
  localparam logic [CNT_BITS-1:0] BREAK_LOAD = CNT_BITS'(BREAK_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] GAP_LOAD   = CNT_BITS'(GAP_CYCLES - 1);
`ifdef UPDI_DB_GUARD_EN
  localparam logic [CNT_BITS-1:0] GUARD_LOAD = CNT_BITS'(GUARD_CYCLES - 1);
`endif
  localparam logic [CNT_BITS-1:0] CNT_ONE    = CNT_BITS'(1);

  state_t              state;
  state_t              state_next;
  logic [CNT_BITS-1:0] cnt;
  logic [CNT_BITS-1:0] cnt_next;
  logic                cnt_zero;
  logic                flush_q;

  assign cnt_zero = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      flush_q <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      // Flush fires only on the transition into DONE, not while parked there.
      flush_q <= (state_next == S_DONE) && (state != S_DONE);
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next = S_WAIT_TX;
        end
      end
      S_WAIT_TX: begin
        if (uart_tx_idle) begin
          state_next = S_BREAK1;
          cnt_next   = BREAK_LOAD;
        end
      end
      S_BREAK1: begin
        if (cnt_zero) begin
          state_next = S_GAP;
          cnt_next   = GAP_LOAD;
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      S_GAP: begin
        if (cnt_zero) begin
          state_next = S_BREAK2;
          cnt_next   = BREAK_LOAD;
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      S_BREAK2: begin
        if (cnt_zero) begin
`ifdef UPDI_DB_GUARD_EN
          state_next = S_GUARD;
          cnt_next   = GUARD_LOAD;
`else
          state_next = S_DONE;
`endif
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
`ifdef UPDI_DB_GUARD_EN
      S_GUARD: begin
        if (cnt_zero) begin
          state_next = S_DONE;
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
`endif
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Moore decode of the registered state.
  always_comb begin
    busy          = 1'b1;
    done          = 1'b0;
    line_override = 1'b0;
    line_value    = 1'b1;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      S_WAIT_TX: begin
        line_override = 1'b0;
      end
      S_BREAK1, S_BREAK2: begin
        line_override = 1'b1;
        line_value    = 1'b0;
      end
      S_GAP: begin
        line_override = 1'b1;
      end
`ifdef UPDI_DB_GUARD_EN
      S_GUARD: begin
        line_override = 1'b1;
      end
`endif
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign uart_rx_flush = flush_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_updi_double_break_gen.sv
// -----------------------------------------------------------------------------
// tb_updi_double_break_gen
//
// Directed bench for updi_double_break_gen with BREAK_CYCLES=10, GAP_CYCLES=4,
// GUARD_CYCLES=3. A phase-arithmetic model (mode + cycles since BREAK1 began)
// predicts every output each cycle; literal checks pin both the DUT and the
// model at hand-computed cycles. Works with or without UPDI_DB_GUARD_EN.
// -----------------------------------------------------------------------------
module tb_updi_double_break_gen;

  localparam int B  = 10;
  localparam int G  = 4;
  localparam int GU = 3;
`ifdef UPDI_DB_GUARD_EN
  localparam int GU_EFF = GU;
`else
  localparam int GU_EFF = 0;
`endif
  localparam int RUN_LEN = 2 * B + G + GU_EFF;  // cycles from BREAK1 start to DONE
  localparam int D       = 2 + RUN_LEN;         // start-to-done latency

  // Bit positions inside the packed output vector {busy,done,ovr,val,flush}.
  localparam int F_BUSY  = 4;
  localparam int F_DONE  = 3;
  localparam int F_OVR   = 2;
  localparam int F_VAL   = 1;
  localparam int F_FLUSH = 0;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       uart_tx_idle;
  logic       busy;
  logic       done;
  logic       line_override;
  logic       line_value;
  logic       uart_rx_flush;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  updi_double_break_gen #(
    .BREAK_CYCLES (B),
    .GAP_CYCLES   (G),
    .GUARD_CYCLES (GU)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .uart_tx_idle  (uart_tx_idle),
    .line_override (line_override),
    .line_value    (line_value),
    .uart_rx_flush (uart_rx_flush),
    .state_dbg     (state_dbg)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 waiting for TX idle, 2 running, 3 done.
  // m_t counts cycles since BREAK1 began; the phase follows from plain ranges.
  int m_mode = 0;
  int m_t    = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      m_mode = 0;
      m_t    = 0;
    end else begin
      case (m_mode)
        0: if (start) m_mode = 1;
        1: if (uart_tx_idle) begin m_mode = 2; m_t = 0; end
        2: begin
          m_t = m_t + 1;
          if (m_t == RUN_LEN) m_mode = 3;
        end
        default: begin
          if (start) m_mode = 1;
          else if (m_t == RUN_LEN) m_t = m_t + 1;
        end
      endcase
    end
  end

  function automatic logic [4:0] model_out();
    logic low;
    case (m_mode)
      0: return 5'b00010;
      1: return 5'b10010;
      2: begin
        low = (m_t < B) || ((m_t >= B + G) && (m_t < 2 * B + G));
        return {1'b1, 1'b0, 1'b1, ~low, 1'b0};
      end
      default: return {1'b0, 1'b1, 1'b0, 1'b1, (m_t == RUN_LEN)};
    endcase
  endfunction

  function automatic logic [4:0] dut_out();
    return {busy, done, line_override, line_value, uart_rx_flush};
  endfunction

  // ---------------- scoreboard: per-cycle compare ----------------
  always @(posedge clk) begin
    logic [4:0] exp_v;
    logic [4:0] got_v;
    #2;
    exp_v = model_out();
    got_v = dut_out();
    vectors = vectors + 1;
    if (got_v !== exp_v) begin
      miscompares = miscompares + 1;
      if (miscompares < 40)
        $display("FAIL cycle_check cyc=%0d {busy,done,ovr,val,flush} got=%b exp=%b",
                 cyc, got_v, exp_v);
    end
  end

  // ---------------- checker helpers ----------------
  task automatic chk(input string name, input logic got, input logic exp_v);
    vectors = vectors + 1;
    if (got !== exp_v) begin
      miscompares = miscompares + 1;
      $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, got, exp_v);
    end
  endtask

  // Pins one output field of both the DUT and the model to a literal.
  task automatic lit(input string name, input int field, input logic exp_v);
    logic [4:0] d;
    logic [4:0] m;
    d = dut_out();
    m = model_out();
    chk({name, "_dut"}, d[field], exp_v);
    chk({name, "_model"}, m[field], exp_v);
  endtask

  // Advance to just after the edge that starts cycle `target`.
  task automatic goto(input int target);
    if (cyc > target) begin
      vectors     = vectors + 1;
      miscompares = miscompares + 1;
      $display("FAIL goto cyc=%0d already past target=%0d", cyc, target);
    end
    while (cyc < target) begin
      @(posedge clk);
      #2;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start(output int c0);
    @(negedge clk);
    start = 1'b1;
    c0    = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    int c1;
    rst          = 1'b1;
    start        = 1'b0;
    uart_tx_idle = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_busy",  busy,          1'b0);
    chk("reset_done",  done,          1'b0);
    chk("reset_ovr",   line_override, 1'b0);
    chk("reset_val",   line_value,    1'b1);
    chk("reset_flush", uart_rx_flush, 1'b0);
    chk("reset_state", (state_dbg == 3'd0), 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // Basic sequence with TX already idle.
    pulse_start(c0);
    goto(c0 + 1);  lit("s1_busy_c1", F_BUSY, 1'b1);  lit("s1_ovr_c1", F_OVR, 1'b0);
    goto(c0 + 2);  lit("s1_ovr_c2", F_OVR, 1'b1);    lit("s1_val_c2", F_VAL, 1'b0);
    goto(c0 + 11); lit("s1_val_c11", F_VAL, 1'b0);
    goto(c0 + 12); lit("s1_val_c12", F_VAL, 1'b1);   lit("s1_ovr_c12", F_OVR, 1'b1);
    goto(c0 + 15); lit("s1_val_c15", F_VAL, 1'b1);
    goto(c0 + 16); lit("s1_val_c16", F_VAL, 1'b0);
    goto(c0 + 25); lit("s1_val_c25", F_VAL, 1'b0);   lit("s1_busy_c25", F_BUSY, 1'b1);
`ifdef UPDI_DB_GUARD_EN
    goto(c0 + 26); lit("s1_guard_val_c26", F_VAL, 1'b1); lit("s1_guard_ovr_c26", F_OVR, 1'b1);
    goto(c0 + 28); lit("s1_guard_ovr_c28", F_OVR, 1'b1); lit("s1_done_c28", F_DONE, 1'b0);
`endif
    goto(c0 + D);     lit("s1_done", F_DONE, 1'b1); lit("s1_flush", F_FLUSH, 1'b1);
    lit("s1_busy_done", F_BUSY, 1'b0); lit("s1_ovr_done", F_OVR, 1'b0);
    goto(c0 + D + 1); lit("s1_flush_off", F_FLUSH, 1'b0); lit("s1_done_hold", F_DONE, 1'b1);

    // TX not idle for 20 cycles; then drop it again mid-break.
    @(negedge clk);
    uart_tx_idle = 1'b0;
    pulse_start(c0);
    goto(c0 + 10); lit("s2_ovr_wait10", F_OVR, 1'b0); lit("s2_busy_wait10", F_BUSY, 1'b1);
    goto(c0 + 20); lit("s2_ovr_wait20", F_OVR, 1'b0); lit("s2_busy_wait20", F_BUSY, 1'b1);
    @(negedge clk);
    uart_tx_idle = 1'b1;
    goto(c0 + 21); lit("s2_ovr_b1", F_OVR, 1'b1); lit("s2_val_b1", F_VAL, 1'b0);
    goto(c0 + 24);
    @(negedge clk);
    uart_tx_idle = 1'b0;
    goto(c0 + 30); lit("s2_val_b1_end", F_VAL, 1'b0);
    goto(c0 + 31); lit("s2_val_gap", F_VAL, 1'b1);
    goto(c0 + 35); lit("s2_val_b2", F_VAL, 1'b0);
    goto(c0 + 21 + RUN_LEN); lit("s2_done", F_DONE, 1'b1);
    @(negedge clk);
    uart_tx_idle = 1'b1;

    // Start from DONE clears done; a start during GAP is ignored.
    pulse_start(c0);
    goto(c0 + 1);  lit("s3_done_clr", F_DONE, 1'b0); lit("s3_busy", F_BUSY, 1'b1);
    goto(c0 + 12);
    pulse_start(c1);
    goto(c0 + 15); lit("s3_val_gap_end", F_VAL, 1'b1);
    goto(c0 + 16); lit("s3_val_b2", F_VAL, 1'b0);
    goto(c0 + D - 1); lit("s3_not_done_yet", F_DONE, 1'b0);
    goto(c0 + D);  lit("s3_done", F_DONE, 1'b1);
    goto(c0 + D + 100); lit("s3_done_sticky", F_DONE, 1'b1); lit("s3_idle_line", F_VAL, 1'b1);
    pulse_start(c1);
    goto(c1 + 1);  lit("s3_restart_clr", F_DONE, 1'b0);
    goto(c1 + 2);  lit("s3_restart_b1", F_VAL, 1'b0);
    goto(c1 + D);  lit("s3_restart_done", F_DONE, 1'b1);

    // Reset in BREAK2 releases the line on the next edge.
    pulse_start(c0);
    goto(c0 + 20); lit("s4_in_b2", F_VAL, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    goto(c0 + 21);
    lit("s4_ovr", F_OVR, 1'b0); lit("s4_val", F_VAL, 1'b1);
    lit("s4_busy", F_BUSY, 1'b0); lit("s4_done", F_DONE, 1'b0);
    chk("s4_state_idle", (state_dbg == 3'd0), 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // start and rst together: reset wins.
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    c0    = cyc;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    goto(c0 + 1); lit("s5_busy", F_BUSY, 1'b0);
    goto(c0 + 3); lit("s5_still_idle", F_BUSY, 1'b0);

    repeat (3) @(posedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
